// File: rtl/fadd_result_collector.sv
// fadd_result_collector: latency-matched capture of adder results, IEEE half fix-up/pack, FWFT FIFO with drop status
module fadd_result_collector #(
  parameter int LATENCY = 4,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic add,
  input  logic [TAG_W-1:0] in_Tag,
  input  logic in_Sign,
  input  logic [4:0] in_Exponent,
  input  logic [9:0] in_Mantissa,
  input  logic in_OverFlow,
  input  logic in_UnderFlow,
  output logic out_valid,
  input  logic out_ready,
  output logic [15:0] out_Result,
  output logic [TAG_W-1:0] out_Tag,
  output logic [1:0] out_Exc,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic overrun,
  output logic [7:0] drop_count
);
  localparam int AW = $clog2(DEPTH);
  logic [LATENCY-1:0] dv;
  logic [TAG_W-1:0] dt [LATENCY];
  logic [15:0] m_res [DEPTH];
  logic [TAG_W-1:0] m_tag [DEPTH];
  logic [1:0] m_exc [DEPTH];
  logic [AW-1:0] wp, rp;
  logic arr, pop, push, drop;
  logic [15:0] packed_w;
  assign out_valid = fifo_count != '0;
  assign out_Result = m_res[rp];
  assign out_Tag = m_tag[rp];
  assign out_Exc = m_exc[rp];
  always_comb begin
    arr = dv[LATENCY-1];
    pop = out_valid && out_ready;
    push = arr && (fifo_count != (AW+1)'(DEPTH) || pop);
    drop = arr && !push;
    packed_w = in_OverFlow ? {in_Sign, 5'h1f, 10'h0} :
               in_UnderFlow ? {in_Sign, 15'h0} : {in_Sign, in_Exponent, in_Mantissa};
  end
  // a push and pop on a full FIFO share a slot: wp == rp, the popped word is read before it is overwritten
  always_ff @(posedge clk) begin
    if (reset) begin
      dv <= '0;
      for (int i = 0; i < LATENCY; i++) dt[i] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        m_res[i] <= '0;
        m_tag[i] <= '0;
        m_exc[i] <= '0;
      end
      wp <= '0;
      rp <= '0;
      fifo_count <= '0;
      overrun <= 1'b0;
      drop_count <= '0;
    end else begin
      dv[0] <= add;
      dt[0] <= in_Tag;
      for (int i = 1; i < LATENCY; i++) begin
        dv[i] <= dv[i-1];
        dt[i] <= dt[i-1];
      end
      if (push) begin
        m_res[wp] <= packed_w;
        m_tag[wp] <= dt[LATENCY-1];
        m_exc[wp] <= {in_OverFlow, in_UnderFlow};
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      if (drop) begin
        overrun <= 1'b1;
        drop_count <= drop_count + {7'd0, drop_count != 8'hff};
      end
    end
  end
endmodule

// File: doc/fadd_result_collector.md
Name: fadd_result_collector

Overview:
- Downstream stage of the pipelined half-precision FP adder.
- Tracks each `add` issue through a delay line matched to the adder latency, then samples the adder's sign/exponent/mantissa/flag outputs when that issue emerges.
- Applies exception fix-up and packs the result into a 16-bit IEEE half word.
- Buffers results in a small first-word-fall-through FIFO with a valid/ready handshake toward the consumer, and keeps sticky/counting status.

Parameters:
- LATENCY, 4, cycles from the clk edge sampling add=1 to the edge where the adder result for that issue is valid.
- DEPTH, 4, FIFO entries (power of 2, ≥2).
- TAG_W, 4, width of the user tag carried alongside each issue.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- add  in  1  issue strobe, sampled the same edge the adder samples its operands.
- in_Tag  in  TAG_W  tag for the issue, sampled with add.
- in_Sign  in  1  adder result sign.
- in_Exponent  in  5  adder result exponent.
- in_Mantissa  in  10  adder result mantissa.
- in_OverFlow  in  1  adder overflow flag.
- in_UnderFlow  in  1  adder exponent-underflow flag.
- out_valid  out  1  FIFO head holds a result.
- out_ready  in  1  consumer accepts head this cycle.
- out_Result  out  16  packed head result {sign, exp[5], mant[10]}.
- out_Tag  out  TAG_W  tag of head.
- out_Exc  out  2  {overflow, underflow} raw flags of head.
- fifo_count  out  clog2(DEPTH)+1  occupancy.
- overrun  out  1  sticky: a result was dropped because the FIFO was full.
- drop_count  out  8  dropped results, saturates at 255.

Behaviour:
- Reset is synchronous, active-high, and has priority over all events.
  - Clears the delay line, all FIFO pointers and entries, overrun and drop_count.
  - Outputs after the reset edge: out_valid=0, out_Result=0, out_Tag=0, out_Exc=0, fifo_count=0.
  - In-flight issues are discarded. A result whose issue preceded reset is never captured, even if the adder still produces it.
- Delay line: LATENCY-stage shift register of {valid, tag}. Stage 0 loads {add, in_Tag} every edge.
- Arrival: when the last stage is valid at edge E (issue at edge E-LATENCY), the adder inputs present before E are sampled.
  - Back-to-back issues, one per cycle, are supported with no bubbles.
- Fix-up before packing (flags copied unchanged to out_Exc):
  - in_OverFlow=1: exp=5'b11111, mant=0, sign preserved (±Inf). Overflow wins if both flags are set.
  - in_UnderFlow=1 only: exp=0, mant=0, sign preserved (±0).
  - Otherwise: fields pass unchanged, including exp=11111 with no flag.
- FIFO is first-word-fall-through. out_* reflect the head combinationally from registered storage.
  - out_valid = (fifo_count != 0).
  - Pop when out_valid && out_ready.
  - out_ready while empty is ignored.
- Push when an arrival occurs and (count<DEPTH or a pop happens the same edge).
  - Push and pop together on a full FIFO: count stays DEPTH, order is preserved.
  - Push and pop together on count=1: the new entry becomes head next cycle.
- Drop: an arrival with count=DEPTH and no pop that edge.
  - The result is discarded, overrun←1, drop_count+1 saturating at 255.
- Pointers wrap modulo DEPTH. fifo_count never exceeds DEPTH or goes below 0.
- Latency: add at edge N gives out_valid=1 after edge N+LATENCY, if the FIFO is not full.

Test Plan:
- Single issue, sign=0 exp=11101 mant=1110111101 driven at N+4 with flags 0 -> after edge N+4 out_valid=1, out_Result=16'h77BD, out_Exc=00, fifo_count=1; out_ready=1 pops, count=0.
- in_OverFlow=1 with sign=1, any exp/mant -> out_Result=16'hFC00, out_Exc=10. in_UnderFlow=1 with sign=0 -> 16'h0000, out_Exc=01. Both flags with sign=0 -> 16'h7C00, out_Exc=11.
- 6 consecutive issues with tags 0..5, out_ready=0 -> tags 0-3 buffered, count=4, tags 4 and 5 dropped, overrun=1, drop_count=2. Then out_ready=1 -> tags 0,1,2,3 delivered in order.
- FIFO full with out_ready=1 and an arrival on the same edge -> count stays 4, no drop, head advances; output order tag sequence is continuous.
- Issue at N, reset asserted at N+2 for one cycle -> no result ever appears, out_valid=0, count=0, overrun=0.
- 300 drops against a permanently full FIFO -> drop_count saturates at 255, overrun stays 1 until reset.
